instruction_memory_loader: RTL and testbench

Byte-stream boot loader that writes a program image into instruction memory before the single-cycle RISC-V core runs. Accepts framed bytes over a valid/ready interface, assembles little-endian 32-bit instruction words, and issues one write per word toward program memory. The core's reset is held through the load and released only after a frame passes its length and checksum checks.

---
 rtl/instruction_memory_loader_if.sv | 27 ++
 rtl/instruction_memory_loader.sv | 143 ++++++++++++++
 tb/tb_instruction_memory_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream receive channel and program-memory write port of the boot loader.
interface instruction_memory_loader_if;
    logic [7:0]  Rx_Data_i;
    logic        Rx_Valid_i;
    logic        Rx_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;

    modport slave (
        input  Rx_Data_i,
        input  Rx_Valid_i,
        output Rx_Ready_o,
        output Mem_Write_o,
        output Mem_Address_o,
        output Mem_Data_o
    );

    modport master (
        output Rx_Data_i,
        output Rx_Valid_i,
        input  Rx_Ready_o,
        input  Mem_Write_o,
        input  Mem_Address_o,
        input  Mem_Data_o
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Framed byte-stream boot loader: assembles little-endian words, writes them to
// program memory and releases the core reset only after length and checksum pass.
module instruction_memory_loader #(
    parameter int unsigned PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS         = 32'h0040_0000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               Start_i,
    instruction_memory_loader_if.slave         bus,
    output logic                               Cpu_Reset_o,
    output logic                               Done_o,
    output logic                               Error_o
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR
    } state_e;

    state_e              state_q;
    logic [BYTE_W-1:0]   len_lo_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    word_idx_q;
    logic [1:0]          byte_idx_q;
    logic [BYTE_W-1:0]   csum_q;
    logic [23:0]         buf_q;
    logic                rx_ready_q;
    logic                mem_write_q;
    logic [WORD_W-1:0]   mem_addr_q;
    logic [WORD_W-1:0]   mem_data_q;
    logic                cpu_reset_q;
    logic                done_q;
    logic                error_q;

    logic                xfer;
    logic [LEN_W-1:0]    len_full;
    logic [LEN_W-1:0]    word_idx_d;
    logic [BYTE_W-1:0]   csum_d;

    assign xfer       = bus.Rx_Valid_i && rx_ready_q;
    assign len_full   = {bus.Rx_Data_i, len_lo_q};
    assign word_idx_d = word_idx_q + LEN_W'(1);
    assign csum_d     = csum_q + bus.Rx_Data_i;

    assign bus.Rx_Ready_o    = rx_ready_q;
    assign bus.Mem_Write_o   = mem_write_q;
    assign bus.Mem_Address_o = mem_addr_q;
    assign bus.Mem_Data_o    = mem_data_q;
    assign Cpu_Reset_o       = cpu_reset_q;
    assign Done_o            = done_q;
    assign Error_o           = error_q;

    // Frame parser; write strobe defaults low so it lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            buf_q       <= '0;
            rx_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start_i) begin
                        state_q     <= S_LEN_LO;
                        rx_ready_q  <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        cpu_reset_q <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo_q <= bus.Rx_Data_i;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        if (len_full == '0 || len_full > LEN_W'(PROGRAM_MEMORY_DEPTH)) begin
                            state_q    <= S_ERROR;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            len_q      <= len_full;
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                            csum_q     <= '0;
                            state_q    <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (xfer) begin
                        csum_q     <= csum_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: buf_q[7:0]   <= bus.Rx_Data_i;
                            2'd1: buf_q[15:8]  <= bus.Rx_Data_i;
                            2'd2: buf_q[23:16] <= bus.Rx_Data_i;
                            default: begin
                                mem_data_q  <= {bus.Rx_Data_i, buf_q};
                                mem_addr_q  <= BASE_ADDRESS + (WORD_W'(word_idx_q) << 2);
                                mem_write_q <= 1'b1;
                                word_idx_q  <= word_idx_d;
                                if (word_idx_d == len_q) begin
                                    state_q <= S_CHECK;
                                end
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        rx_ready_q <= 1'b0;
                        if (bus.Rx_Data_i == csum_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench: directed and random frames against a frame-level reference model.
module tb_instruction_memory_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic cpu_rst, done, err;
    instruction_memory_loader_if bus();

    instruction_memory_loader #(
        .PROGRAM_MEMORY_DEPTH(64),
        .BASE_ADDRESS        (32'h0040_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Start_i    (start),
        .bus        (bus),
        .Cpu_Reset_o(cpu_rst),
        .Done_o     (done),
        .Error_o    (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write log
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    always @(negedge clk) begin
        if (bus.Mem_Write_o) begin
            wa.push_back(bus.Mem_Address_o);
            wd.push_back(bus.Mem_Data_o);
            wc.push_back(cyc);
        end
    end

    logic [7:0] frame[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.Rx_Ready_o), 32'd0);
        chk({tag, "_write"}, 32'(bus.Mem_Write_o), 32'd0);
        chk({tag, "_addr"}, bus.Mem_Address_o, 32'd0);
        chk({tag, "_data"}, bus.Mem_Data_o, 32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(err), 32'd0);
    endtask

    // Entered and left at posedge+1
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        if (gap > 0) begin
            bus.Rx_Valid_i = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        bus.Rx_Data_i  = b;
        bus.Rx_Valid_i = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.Rx_Ready_o) break;
        end
        if (k == 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_ready_timeout: observed no ready within 20 cycles, required ready");
            bus.Rx_Valid_i = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", 32'(bus.Rx_Ready_o), 32'd1);
        chk("cpurst_after_start", 32'(cpu_rst), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
        chk("error_after_start", 32'(err), 32'd0);
    endtask

    task automatic build_frame(input logic [15:0] nf, input bit bad);
        logic [7:0] s;
        logic [7:0] b;
        frame.delete();
        frame.push_back(nf[7:0]);
        frame.push_back(nf[15:8]);
        if (nf >= 16'd1 && nf <= 16'd64) begin
            s = 8'd0;
            for (int i = 0; i < 4 * int'(nf); i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                s = s + b;
            end
            frame.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
        end
    endtask

    // Reference: frame rules evaluated directly on the byte list
    task automatic run_frame(input string tag, input int maxgap);
        int          n;
        bit          len_ok;
        int          nsend;
        int          sum;
        bit          exp_done;
        logic [31:0] ea;
        logic [31:0] ed;
        n      = int'(frame[1]) * 256 + int'(frame[0]);
        len_ok = (n >= 1) && (n <= 64);
        nsend  = len_ok ? 2 + 4 * n + 1 : 2;
        sum    = 0;
        if (len_ok) for (int i = 0; i < 4 * n; i++) sum = (sum + int'(frame[2 + i])) % 256;
        exp_done = len_ok && (int'(frame[nsend - 1]) == sum);

        wa.delete(); wd.delete(); wc.delete();
        do_start();
        for (int i = 0; i < nsend; i++) send_byte(frame[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        bus.Rx_Valid_i = 1'b0;

        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(err), 32'(!exp_done));
        chk({tag, "_cpurst"}, 32'(cpu_rst), 32'(!exp_done));
        chk({tag, "_ready_end"}, 32'(bus.Rx_Ready_o), 32'd0);
        chk({tag, "_nwrites"}, 32'(wa.size()), len_ok ? 32'(n) : 32'd0);
        if (len_ok && wa.size() == n) begin
            for (int i = 0; i < n; i++) begin
                ea = 32'h0040_0000 + 32'(4 * i);
                ed = {frame[5 + 4*i], frame[4 + 4*i], frame[3 + 4*i], frame[2 + 4*i]};
                chk({tag, "_addr"}, wa[i], ea);
                chk({tag, "_data"}, wd[i], ed);
                if (maxgap == 0 && i > 0) chk({tag, "_spacing"}, 32'(wc[i] - wc[i-1]), 32'd4);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        bus.Rx_Valid_i = 1'b0;
        bus.Rx_Data_i  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single word addi x10,x0,10
        frame.delete();
        frame.push_back(8'h01); frame.push_back(8'h00);
        frame.push_back(8'h13); frame.push_back(8'h05); frame.push_back(8'hA0); frame.push_back(8'h00);
        frame.push_back(8'hB8);
        run_frame("single", 0);
        if (wd.size() == 1) chk("single_literal_data", wd[0], 32'h00A0_0513);

        // Rx_Valid_i while not ready must not disturb DONE
        bus.Rx_Data_i  = 8'h5A;
        bus.Rx_Valid_i = 1'b1;
        wa.delete();
        repeat (3) begin @(posedge clk); #1; end
        bus.Rx_Valid_i = 1'b0;
        chk("idle_valid_done", 32'(done), 32'd1);
        chk("idle_valid_nwrites", 32'(wa.size()), 32'd0);

        build_frame(16'd3, 1'b0);
        run_frame("three", 0);

        frame[frame.size() - 1] = 8'hB9;
        frame.delete();
        frame.push_back(8'h01); frame.push_back(8'h00);
        frame.push_back(8'h13); frame.push_back(8'h05); frame.push_back(8'hA0); frame.push_back(8'h00);
        frame.push_back(8'hB9);
        run_frame("badsum", 0);

        build_frame(16'd0, 1'b0);
        run_frame("len0", 0);
        build_frame(16'd65, 1'b0);
        run_frame("len65", 0);
        build_frame(16'd64, 1'b0);
        run_frame("len64", 0);
        if (wa.size() == 64) chk("len64_last_addr", wa[63], 32'h0040_00FC);

        build_frame(16'd2, 1'b0);
        run_frame("stall", 3);

        // Reset during PAYLOAD while the write strobe is high
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        bus.Rx_Valid_i = 1'b0;
        chk("midload_write_high", 32'(bus.Mem_Write_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("midload");
        @(posedge clk); #1;
        reset = 1'b0;
        build_frame(16'd2, 1'b0);
        run_frame("after_reset", 0);

        for (int t = 0; t < 20; t++) begin
            int          sel;
            logic [15:0] nf;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      nf = 16'd0;
            else if (sel == 1) nf = 16'($urandom_range(65, 1000));
            else               nf = 16'($urandom_range(1, 8));
            build_frame(nf, $urandom_range(0, 3) == 0);
            run_frame("rand", int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
